// File: rtl/rv_wb_pkg.sv
// Shared writeback types: write-kind encoding seen by Reg_file and the load-stage FSM states.
package rv_wb_pkg;

  // Byte-enable style write kinds; NONE doubles as the bubble/store marker.
  typedef enum logic [2:0] {
    NONE = 3'b000,
    BYTE = 3'b001,
    HALF = 3'b011,
    WORD = 3'b111
  } wb_kind_e;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_e;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_load_stage_load_align.sv
// Load data alignment: picks the addressed byte/half lane of a little-endian
// read word, sign- or zero-extends it, and flags misaligned half/word accesses.
module load_align
  import rv_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  kind,
  input  logic        is_unsigned,
  output logic [31:0] data32,
  output logic        misalign
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Split the read word into its four byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = rdata[8*gi +: 8];
  end

  // Lane select and extension; HALF ignores addr_lo[0] but still reports it.
  always_comb begin
    byte_lane = lanes[addr_lo];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data32    = rdata;
    misalign  = 1'b0;
    case (kind)
      BYTE: data32 = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      HALF: begin
        data32   = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
        misalign = addr_lo[0];
      end
      WORD:    misalign = (addr_lo != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_load_stage.sv
// MEM->WB pipeline register. ALU results retire one cycle after MEM; loads
// wait for the data-memory response (stalling upstream via waiting), are
// aligned/extended, then retire. A bounded wait drops a lost load as a bubble.
module wb_load_stage
  import rv_wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [2:0]  mem_wb_kind,
  input  logic        mem_is_load,
  input  logic        mem_unsigned,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_result,
  input  logic        flush,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [2:0]  Regwrite,
  output logic        waiting,
  output logic        misalign_err,
  output logic        load_timeout
);

  wb_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [4:0]       wr_rd_reg, wr_rd_next;
  logic [31:0]      wr_data_reg, wr_data_next;
  logic [2:0]       wr_kind_reg, wr_kind_next;
  logic             misalign_reg, misalign_next;

  logic             load_req;
  logic             timeout_hit;
  logic             retire_load;
  logic             retire_alu;
  logic [31:0]      align_data;
  logic             align_misalign;

  // Stores (kind NONE) never count as loads even if is_load is set.
  assign load_req    = mem_valid & mem_is_load & (mem_wb_kind != NONE);
  assign timeout_hit = (state_reg == LOAD_WAIT) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  load_align u_align (
    .rdata       (dm_rdata),
    .addr_lo     (mem_addr_lo),
    .kind        (mem_wb_kind),
    .is_unsigned (mem_unsigned),
    .data32      (align_data),
    .misalign    (align_misalign)
  );

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: flush wins, then response, then timeout expiry.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = RUN;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (load_req && !dm_rvalid) begin
            state_next = LOAD_WAIT;
            cnt_next   = '0;
          end
        end
        LOAD_WAIT: begin
          if (dm_rvalid) begin
            state_next = RUN;
          end else if (timeout_hit) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Outputs: stall/timeout strobes and the value to retire next cycle.
  always_comb begin
    waiting       = 1'b0;
    load_timeout  = 1'b0;
    retire_load   = 1'b0;
    retire_alu    = 1'b0;
    wr_rd_next    = ZERO_REG;
    wr_data_next  = '0;
    wr_kind_next  = NONE;
    misalign_next = 1'b0;
    if (!flush) begin
      case (state_reg)
        RUN: begin
          waiting     = load_req & ~dm_rvalid;
          retire_load = load_req & dm_rvalid;
          retire_alu  = mem_valid & ~mem_is_load & (mem_wb_kind != NONE);
        end
        LOAD_WAIT: begin
          waiting      = ~dm_rvalid & ~timeout_hit;
          load_timeout = ~dm_rvalid & timeout_hit;
          retire_load  = dm_rvalid;
        end
        default: ;
      endcase
    end
    // Writes to x0 are squashed to bubbles; misalignment is still reported.
    if (retire_load) begin
      misalign_next = align_misalign;
      if (mem_rd != ZERO_REG) begin
        wr_rd_next   = mem_rd;
        wr_data_next = align_data;
        wr_kind_next = mem_wb_kind;
      end
    end else if (retire_alu && (mem_rd != ZERO_REG)) begin
      wr_rd_next   = mem_rd;
      wr_data_next = mem_result;
      wr_kind_next = mem_wb_kind;
    end
  end

  // Writeback registers driving the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_rd_reg    <= ZERO_REG;
      wr_data_reg  <= '0;
      wr_kind_reg  <= NONE;
      misalign_reg <= 1'b0;
    end else begin
      wr_rd_reg    <= wr_rd_next;
      wr_data_reg  <= wr_data_next;
      wr_kind_reg  <= wr_kind_next;
      misalign_reg <= misalign_next;
    end
  end

  assign write_reg    = wr_rd_reg;
  assign write_data   = wr_data_reg;
  assign Regwrite     = wr_kind_reg;
  assign misalign_err = misalign_reg;

endmodule
